// File: rtl/ksa32_share_ctrl.sv
// Round-robin sequencer sharing one combinational 32-bit adder among N requesters.
// Subtraction runs as two adder passes: A + ~B, then + 1.
module ksa32_share_ctrl #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N-1:0]      REQ_VALID,
  output logic [N-1:0]      REQ_READY,
  input  logic [32*N-1:0]   REQ_A,
  input  logic [32*N-1:0]   REQ_B,
  input  logic [N-1:0]      REQ_SUB,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [31:0]       RSP_SUM,
  output logic              RSP_COUT,
  output logic              RSP_OVF,
  output logic [31:0]       ADD_A,
  output logic [31:0]       ADD_B,
  input  logic [31:0]       ADD_SUM,
  input  logic              ADD_COUT,
  input  logic              ADD_OVF
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_reg;
  logic           sub_reg;
  logic           c1_reg;
  logic           a_msb;
  logic           b_msb;

  logic           grant_valid;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           sel_sub;

  function automatic int unsigned rr_idx(input logic [IDW-1:0] p, input int unsigned k);
    return (32'(p) + k) % N;
  endfunction

  // First valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_sub     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!grant_valid && REQ_VALID[rr_idx(ptr, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'(rr_idx(ptr, k));
        sel_a       = REQ_A[rr_idx(ptr, k)*W +: W];
        sel_b       = REQ_B[rr_idx(ptr, k)*W +: W];
        sel_sub     = REQ_SUB[rr_idx(ptr, k)];
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (state == IDLE && grant_valid && !RST) begin
      REQ_READY = N'(1) << grant_idx;
    end
  end

  // Sequencer; adder operands are registered so they are valid throughout each pass.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      id_reg    <= '0;
      sub_reg   <= 1'b0;
      c1_reg    <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_SUM   <= '0;
      RSP_COUT  <= 1'b0;
      RSP_OVF   <= 1'b0;
      ADD_A     <= '0;
      ADD_B     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            id_reg  <= grant_idx;
            sub_reg <= sel_sub;
            a_msb   <= sel_a[W-1];
            b_msb   <= sel_b[W-1];
            ptr     <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
            ADD_A   <= sel_a;
            ADD_B   <= sel_sub ? ~sel_b : sel_b;
            state   <= PASS1;
          end
        end
        PASS1: begin
          c1_reg <= ADD_COUT;
          if (sub_reg) begin
            ADD_A <= ADD_SUM;
            ADD_B <= W'(1);
            state <= PASS2;
          end else begin
            RSP_SUM   <= ADD_SUM;
            RSP_COUT  <= ADD_COUT;
            RSP_OVF   <= ADD_OVF;
            RSP_ID    <= id_reg;
            RSP_VALID <= 1'b1;
            ADD_A     <= '0;
            ADD_B     <= '0;
            state     <= RESP;
          end
        end
        PASS2: begin
          // Signed overflow of A - B uses the original operand signs, not the adder flag.
          RSP_SUM   <= ADD_SUM;
          RSP_COUT  <= c1_reg | ADD_COUT;
          RSP_OVF   <= (a_msb ^ b_msb) & (ADD_SUM[W-1] ^ a_msb);
          RSP_ID    <= id_reg;
          RSP_VALID <= 1'b1;
          ADD_A     <= '0;
          ADD_B     <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa32_share_ctrl.sv
// Self-checking bench for ksa32_share_ctrl with a behavioural adder and arithmetic reference model.
module tb_ksa32_share_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      REQ_VALID;
  logic [N-1:0]      REQ_READY;
  logic [32*N-1:0]   REQ_A;
  logic [32*N-1:0]   REQ_B;
  logic [N-1:0]      REQ_SUB;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [IDW-1:0]    RSP_ID;
  logic [31:0]       RSP_SUM;
  logic              RSP_COUT;
  logic              RSP_OVF;
  logic [31:0]       ADD_A;
  logic [31:0]       ADD_B;
  logic [31:0]       ADD_SUM;
  logic              ADD_COUT;
  logic              ADD_OVF;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // Stand-in for the shared adder: no carry-in, flags from operand and result signs.
  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B};
  assign ADD_OVF = (ADD_A[31] == ADD_B[31]) && (ADD_SUM[31] != ADD_A[31]);

  ksa32_share_ctrl #(.N(N), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_SUB(REQ_SUB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_SUM(RSP_SUM), .RSP_COUT(RSP_COUT), .RSP_OVF(RSP_OVF),
    .ADD_A(ADD_A), .ADD_B(ADD_B),
    .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT), .ADD_OVF(ADD_OVF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] s;
    logic        c;
    longint      r;
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s = a + b;
      c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
      r = longint'($signed(a)) + longint'($signed(b));
    end
    return {(r > 64'sd2147483647) || (r < -64'sd2147483648), c, s};
  endfunction

  task automatic pulse_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!RSP_VALID && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  // Single-requester operation with RSP_READY high; entered and left at posedge+1.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input string tag);
    logic [33:0] e;
    int lat;
    e = model(a, b, sub);
    REQ_A[idx*32 +: 32] = a;
    REQ_B[idx*32 +: 32] = b;
    REQ_SUB[idx]        = sub;
    REQ_VALID           = N'(1) << idx;
    #1;
    chk({tag, ".grant"}, 32'(REQ_READY), 32'(N'(1) << idx));
    @(posedge CLK); #1;
    REQ_VALID = '0;
    chk({tag, ".ready_low"}, 32'(REQ_READY), 32'd0);
    wait_rsp(lat);
    chk({tag, ".latency"}, 32'(lat), sub ? 32'd3 : 32'd2);
    chk({tag, ".id"},   32'(RSP_ID),   32'(idx));
    chk({tag, ".sum"},  RSP_SUM,       e[31:0]);
    chk({tag, ".cout"}, 32'(RSP_COUT), 32'(e[32]));
    chk({tag, ".ovf"},  32'(RSP_OVF),  32'(e[33]));
    @(posedge CLK); #1;
    chk({tag, ".valid_drop"}, 32'(RSP_VALID), 32'd0);
  endtask

  initial begin
    logic [33:0] e;
    int lat;
    int w;
    logic [31:0] bp_sum;

    RST = 1'b1; REQ_VALID = '0; REQ_A = '0; REQ_B = '0; REQ_SUB = '0; RSP_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst.valid", 32'(RSP_VALID), 32'd0);
    chk("rst.id",    32'(RSP_ID),    32'd0);
    chk("rst.sum",   RSP_SUM,        32'd0);
    chk("rst.cout",  32'(RSP_COUT),  32'd0);
    chk("rst.ovf",   32'(RSP_OVF),   32'd0);
    chk("rst.add_a", ADD_A,          32'd0);
    chk("rst.add_b", ADD_B,          32'd0);
    chk("rst.ready", 32'(REQ_READY), 32'd0);

    // Directed arithmetic cases.
    run_op(1, 32'd5, 32'd7, 1'b0, "add5p7");
    run_op(0, 32'd5, 32'd7, 1'b1, "sub5m7");
    run_op(0, 32'd7, 32'd5, 1'b1, "sub7m5");
    run_op(0, 32'd0, 32'd0, 1'b1, "sub0m0");
    run_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, "add_ovf");
    run_op(3, 32'h8000_0000, 32'd1, 1'b1, "sub_ovf");
    run_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, "add_carry");
    chk("lit.sub5m7", model(32'd5, 32'd7, 1'b1), {1'b0, 1'b0, 32'hFFFF_FFFE});

    // Round-robin with every requester valid.
    pulse_reset();
    for (int i = 0; i < int'(N); i++) begin
      REQ_A[i*32 +: 32] = $urandom;
      REQ_B[i*32 +: 32] = $urandom;
    end
    REQ_SUB   = '0;
    REQ_VALID = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (REQ_READY == '0 && w < 10) begin
        @(posedge CLK); #1;
        w++;
      end
      chk("rr.grant", 32'(REQ_READY), 32'(N'(1) << (k % N)));
      @(posedge CLK); #1;
      chk("rr.pulse", 32'(REQ_READY), 32'd0);
      wait_rsp(lat);
      e = model(REQ_A[(k%N)*32 +: 32], REQ_B[(k%N)*32 +: 32], 1'b0);
      chk("rr.id",  32'(RSP_ID), 32'(k % N));
      chk("rr.sum", RSP_SUM,     e[31:0]);
      @(posedge CLK); #1;
    end
    REQ_VALID = '0;
    w = 0;
    while ((RSP_VALID || ADD_A != '0) && w < 10) begin
      @(posedge CLK); #1;
      w++;
    end
    pulse_reset();

    // Backpressure: response held while requester 3 waits.
    RSP_READY = 1'b0;
    REQ_A[2*32 +: 32] = 32'h1234_5678; REQ_B[2*32 +: 32] = 32'h8765_4321; REQ_SUB[2] = 1'b1;
    REQ_A[3*32 +: 32] = 32'h0000_0010; REQ_B[3*32 +: 32] = 32'h0000_0020; REQ_SUB[3] = 1'b0;
    REQ_VALID = 4'b0100;
    #1;
    chk("bp.grant2", 32'(REQ_READY), 32'h4);
    @(posedge CLK); #1;
    REQ_VALID = 4'b1000;
    wait_rsp(lat);
    e = model(32'h1234_5678, 32'h8765_4321, 1'b1);
    bp_sum = e[31:0];
    chk("bp.latency", 32'(lat), 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      chk("bp.valid", 32'(RSP_VALID), 32'd1);
      chk("bp.sum",   RSP_SUM,        bp_sum);
      chk("bp.flags", {30'd0, RSP_OVF, RSP_COUT}, {30'd0, e[33], e[32]});
      chk("bp.ready", 32'(REQ_READY), 32'd0);
    end
    chk("bp.id", 32'(RSP_ID), 32'd2);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    chk("bp.done",   32'(RSP_VALID), 32'd0);
    chk("bp.grant3", 32'(REQ_READY), 32'h8);
    @(posedge CLK); #1;
    REQ_VALID = '0;
    wait_rsp(lat);
    chk("bp.id3",  32'(RSP_ID), 32'd3);
    chk("bp.sum3", RSP_SUM,     32'h0000_0030);
    @(posedge CLK); #1;

    // Reset during PASS2 of a subtract.
    REQ_A[1*32 +: 32] = 32'd100; REQ_B[1*32 +: 32] = 32'd1; REQ_SUB[1] = 1'b1;
    REQ_VALID = 4'b0010;
    #1;
    @(posedge CLK); #1;
    REQ_VALID = '0;
    @(posedge CLK); #1;
    chk("mid.pass2", ADD_B, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("mid.valid", 32'(RSP_VALID), 32'd0);
    chk("mid.sum",   RSP_SUM,        32'd0);
    chk("mid.id",    32'(RSP_ID),    32'd0);
    chk("mid.flags", {30'd0, RSP_OVF, RSP_COUT}, 32'd0);
    chk("mid.add_a", ADD_A,          32'd0);
    chk("mid.add_b", ADD_B,          32'd0);
    chk("mid.ready", 32'(REQ_READY), 32'd0);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("mid.no_rsp", 32'(RSP_VALID), 32'd0);
    end
    REQ_A[0] = 1'b0;
    REQ_VALID = '1;
    #1;
    chk("mid.grant0", 32'(REQ_READY), 32'h1);
    @(posedge CLK); #1;
    REQ_VALID = '0;
    wait_rsp(lat);
    e = model(REQ_A[31:0], REQ_B[31:0], REQ_SUB[0]);
    chk("mid.id0",  32'(RSP_ID), 32'd0);
    chk("mid.sum0", RSP_SUM,     e[31:0]);
    @(posedge CLK); #1;

    // Randomized operations against the model.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = a;
      run_op(int'($urandom_range(0, N - 1)), a, b, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
